multi_cook_timer: RTL and testbench

- Parameterised successor of the single-channel cook timer: NUM_CH independent countdown channels (mm:ss, BCD).
- Each channel has its own set time, run/pause state, and alarm.
- One shared button set edits and controls the currently selected channel.
- Outputs a 16-bit BCD display word for the 4-digit FND controller, plus per-channel alarm/running flags for LEDs/buzzer logic.

---
 rtl/multi_cook_timer.sv | 213 +++++++++++++++++++++
 tb/tb_multi_cook_timer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cook_timer.sv
// multi_cook_timer: NUM_CH independent mm:ss BCD countdown channels that share
// one button set. The selected channel is edited/controlled by the buttons and
// its time is presented on a 16-bit BCD display word.
// Optional build macro: AUTO_SILENCE_EN (alarm self-clears after ALARM_SEC s).
module multi_cook_timer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int NUM_CH      = 2,
  parameter int MAX_MIN     = 59,
  parameter int ALARM_SEC   = 30
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              btn_start,
  input  logic              btn_sec,
  input  logic              btn_min,
  input  logic              btn_stop,
  input  logic              btn_sel,
  output logic [2:0]        sel_ch,
  output logic [15:0]       value,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] alarm,
  output logic              alarm_any
);

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_FREQ_HZ - 1);
  localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_ALARM
  } state_t;

  state_t        r_state     [NUM_CH];
  state_t        w_state_nxt [NUM_CH];
  logic [7:0]    r_set_min   [NUM_CH];
  logic [7:0]    r_set_sec   [NUM_CH];
  logic [7:0]    r_cur_min   [NUM_CH];
  logic [7:0]    r_cur_sec   [NUM_CH];
  logic [PW-1:0] r_presc     [NUM_CH];

  logic [2:0]        r_sel;
  logic [15:0]       r_value;
  logic [NUM_CH-1:0] r_running;
  logic [NUM_CH-1:0] r_alarm;

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_counting;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_cur_one;
  logic [NUM_CH-1:0] w_set_zero;
  logic [15:0]       w_value;

`ifdef AUTO_SILENCE_EN
  localparam int AW = $clog2(ALARM_SEC + 1);
  logic [AW-1:0] r_asec [NUM_CH];
`else
  logic w_unused_alarm_sec;
  assign w_unused_alarm_sec = ^ALARM_SEC;
`endif

  // BCD increment with wrap to 00 once the limit is reached
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim)              return '0;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement; caller guarantees v != 00
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Per-channel decodes: selection, prescaler tick, time comparisons
  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      w_sel[ch]      = (r_sel == 3'(ch));
`ifdef AUTO_SILENCE_EN
      w_counting[ch] = (r_state[ch] == ST_RUN) || (r_state[ch] == ST_ALARM);
`else
      w_counting[ch] = (r_state[ch] == ST_RUN);
`endif
      w_tick[ch]     = w_counting[ch] && (r_presc[ch] == PRESC_TERM);
      w_cur_one[ch]  = (r_cur_min[ch] == 8'h00) && (r_cur_sec[ch] == 8'h01);
      w_set_zero[ch] = (r_set_min[ch] == 8'h00) && (r_set_sec[ch] == 8'h00);
    end
  end

  // Next-state logic for every channel; stop always wins over start
  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      unique case (r_state[ch])
        ST_IDLE: begin
          if (w_sel[ch] && btn_start && !btn_stop && !w_set_zero[ch])
            w_state_nxt[ch] = ST_RUN;
        end
        ST_RUN: begin
          if (w_sel[ch] && btn_stop)
            w_state_nxt[ch] = ST_IDLE;
          else if (w_tick[ch] && w_cur_one[ch])
            w_state_nxt[ch] = ST_ALARM;
          else if (w_sel[ch] && btn_start)
            w_state_nxt[ch] = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (w_sel[ch] && btn_stop)
            w_state_nxt[ch] = ST_IDLE;
          else if (w_sel[ch] && btn_start)
            w_state_nxt[ch] = ST_RUN;
        end
        ST_ALARM: begin
          if (w_sel[ch] && btn_stop)
            w_state_nxt[ch] = ST_IDLE;
`ifdef AUTO_SILENCE_EN
          else if (w_tick[ch] && (r_asec[ch] == AW'(ALARM_SEC - 1)))
            w_state_nxt[ch] = ST_IDLE;
`endif
        end
        default: w_state_nxt[ch] = ST_IDLE;
      endcase
    end
  end

  // Channel registers: state, set time, countdown time, prescaler
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch]   <= ST_IDLE;
        r_set_min[ch] <= '0;
        r_set_sec[ch] <= '0;
        r_cur_min[ch] <= '0;
        r_cur_sec[ch] <= '0;
        r_presc[ch]   <= '0;
`ifdef AUTO_SILENCE_EN
        r_asec[ch]    <= '0;
`endif
      end
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch] <= w_state_nxt[ch];

        if ((r_state[ch] == ST_IDLE) && w_sel[ch]) begin
          if (btn_sec) r_set_sec[ch] <= bcd_inc(r_set_sec[ch], 8'h59);
          if (btn_min) r_set_min[ch] <= bcd_inc(r_set_min[ch], MAX_MIN_BCD);
        end

        if ((r_state[ch] == ST_IDLE) && (w_state_nxt[ch] == ST_RUN)) begin
          r_cur_min[ch] <= r_set_min[ch];
          r_cur_sec[ch] <= r_set_sec[ch];
          r_presc[ch]   <= '0;
        end else if (w_counting[ch]) begin
          r_presc[ch] <= w_tick[ch] ? '0 : r_presc[ch] + PW'(1);
          if (w_tick[ch] && (r_state[ch] == ST_RUN)) begin
            if (r_cur_sec[ch] == 8'h00) begin
              r_cur_sec[ch] <= 8'h59;
              r_cur_min[ch] <= bcd_dec(r_cur_min[ch]);
            end else begin
              r_cur_sec[ch] <= bcd_dec(r_cur_sec[ch]);
            end
          end
        end

`ifdef AUTO_SILENCE_EN
        // Alarm entry always coincides with a tick, so the prescaler
        // restarts from 0 together with the silence counter.
        if ((r_state[ch] != ST_ALARM) && (w_state_nxt[ch] == ST_ALARM))
          r_asec[ch] <= '0;
        else if ((r_state[ch] == ST_ALARM) && w_tick[ch])
          r_asec[ch] <= r_asec[ch] + AW'(1);
`endif
      end
    end
  end

  // Display source: set time while idle, countdown time otherwise
  always_comb begin
    w_value = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (w_sel[ch])
        w_value = (r_state[ch] == ST_IDLE) ? {r_set_min[ch], r_set_sec[ch]}
                                           : {r_cur_min[ch], r_cur_sec[ch]};
    end
  end

  // Channel selection and registered outputs
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_sel     <= '0;
      r_value   <= '0;
      r_running <= '0;
      r_alarm   <= '0;
    end else begin
      if (btn_sel)
        r_sel <= (r_sel == 3'(NUM_CH - 1)) ? '0 : r_sel + 3'd1;
      r_value <= w_value;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        r_running[ch] <= (r_state[ch] == ST_RUN);
        r_alarm[ch]   <= (r_state[ch] == ST_ALARM);
      end
    end
  end

  assign sel_ch    = r_sel;
  assign value     = r_value;
  assign running   = r_running;
  assign alarm     = r_alarm;
  assign alarm_any = |r_alarm;

endmodule

// File: tb/tb_multi_cook_timer.sv
// Directed testbench for multi_cook_timer (CLK_FREQ_HZ=10, NUM_CH=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_cook_timer;

  localparam logic [4:0] B_START = 5'b00001;
  localparam logic [4:0] B_SEC   = 5'b00010;
  localparam logic [4:0] B_MIN   = 5'b00100;
  localparam logic [4:0] B_STOP  = 5'b01000;
  localparam logic [4:0] B_SEL   = 5'b10000;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        btn_start, btn_sec, btn_min, btn_stop, btn_sel;
  logic [2:0]  sel_ch;
  logic [15:0] value;
  logic [1:0]  running;
  logic [1:0]  alarm;
  logic        alarm_any;

  int checks   = 0;
  int failures = 0;

  multi_cook_timer #(
    .CLK_FREQ_HZ(10),
    .NUM_CH     (2),
    .MAX_MIN    (59),
    .ALARM_SEC  (3)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .btn_start(btn_start),
    .btn_sec  (btn_sec),
    .btn_min  (btn_min),
    .btn_stop (btn_stop),
    .btn_sel  (btn_sel),
    .sel_ch   (sel_ch),
    .value    (value),
    .running  (running),
    .alarm    (alarm),
    .alarm_any(alarm_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse on the buttons in mask; returns one negedge later
  task automatic press(input logic [4:0] m);
    btn_start = m[0];
    btn_sec   = m[1];
    btn_min   = m[2];
    btn_stop  = m[3];
    btn_sel   = m[4];
    @(negedge clk);
    btn_start = 1'b0;
    btn_sec   = 1'b0;
    btn_min   = 1'b0;
    btn_stop  = 1'b0;
    btn_sel   = 1'b0;
  endtask

  task automatic press_n(input logic [4:0] m, input int n);
    repeat (n) press(m);
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    step(2);
    reset_p = 1'b0;
    step(1);
  endtask

  initial begin
    reset_p = 1'b1;
    btn_start = 1'b0; btn_sec = 1'b0; btn_min = 1'b0; btn_stop = 1'b0; btn_sel = 1'b0;
    step(3);
    reset_p = 1'b0;
    step(1);
    check("rst_value", 32'(value), 32'h0000);
    check("rst_running", 32'(running), 32'h0);
    check("rst_alarm", 32'(alarm), 32'h0);
    check("rst_alarm_any", 32'(alarm_any), 32'h0);
    check("rst_sel", 32'(sel_ch), 32'h0);

    // Basic countdown from 01:03
    press_n(B_SEC, 3);
    press(B_MIN);
    press(B_START);
    step(1);
    check("t1_value_start", 32'(value), 32'h0103);
    check("t1_running", 32'(running), 32'h1);
    step(9);
    check("t1_value_pre_tick", 32'(value), 32'h0103);
    step(1);
    check("t1_value_tick", 32'(value), 32'h0102);
    press(B_STOP);
    step(1);
    check("t1_cancel_running", 32'(running), 32'h0);
    check("t1_cancel_value", 32'(value), 32'h0103);

    // Alarm from 00:02
    do_reset();
    press_n(B_SEC, 2);
    press(B_START);
    step(20);
    check("t2_alarm_pre", 32'(alarm), 32'h0);
    step(1);
    check("t2_alarm", 32'(alarm), 32'h1);
    check("t2_alarm_any", 32'(alarm_any), 32'h1);
    check("t2_value", 32'(value), 32'h0000);
    check("t2_running", 32'(running), 32'h0);
    press(B_START);
    step(1);
    check("t2_start_ignored", 32'(alarm), 32'h1);
    press(B_STOP);
    step(1);
    check("t2_ack_alarm", 32'(alarm), 32'h0);
    check("t2_ack_any", 32'(alarm_any), 32'h0);
    check("t2_ack_value", 32'(value), 32'h0002);

    // Two channels in parallel
    do_reset();
    press_n(B_SEC, 5);
    press(B_START);
    press(B_SEL);
    press_n(B_SEC, 3);
    press(B_START);
    step(1);
    check("t3_both_running", 32'(running), 32'h3);
    check("t3_sel1", 32'(sel_ch), 32'h1);
    check("t3_value_ch1", 32'(value), 32'h0003);
    step(29);
    check("t3_alarm_pre", 32'(alarm), 32'h0);
    step(1);
    check("t3_alarm_ch1", 32'(alarm), 32'h2);
    check("t3_running_ch0", 32'(running), 32'h1);
    press(B_SEL);
    step(1);
    check("t3_sel_wrap", 32'(sel_ch), 32'h0);
    check("t3_value_ch0", 32'(value), 32'h0002);
    step(12);
    check("t3_alarm_ch0_pre", 32'(alarm), 32'h2);
    step(1);
    check("t3_alarm_both", 32'(alarm), 32'h3);
    check("t3_alarm_any", 32'(alarm_any), 32'h1);

    // Reset in the middle of alarms
    do_reset();
    check("mid_rst_alarm", 32'(alarm), 32'h0);
    check("mid_rst_value", 32'(value), 32'h0000);
    check("mid_rst_sel", 32'(sel_ch), 32'h0);

    // Pause and resume keep the prescaler phase
    press_n(B_SEC, 10);
    step(1);
    check("t4_set_0010", 32'(value), 32'h0010);
    press(B_START);
    step(14);
    press(B_START);
    step(1);
    check("t4_pause_value", 32'(value), 32'h0009);
    check("t4_pause_running", 32'(running), 32'h0);
    press(B_SEC);
    step(100);
    check("t4_frozen", 32'(value), 32'h0009);
    press(B_START);
    step(5);
    check("t4_resume_pre", 32'(value), 32'h0009);
    step(1);
    check("t4_resume_tick", 32'(value), 32'h0008);

    // Edge cases
    do_reset();
    press(B_START);
    step(1);
    check("t5_zero_start", 32'(running), 32'h0);
    press_n(B_SEC, 59);
    step(1);
    check("t5_sec59", 32'(value), 32'h0059);
    press(B_SEC);
    step(1);
    check("t5_sec_wrap", 32'(value), 32'h0000);
    press_n(B_MIN, 59);
    step(1);
    check("t5_min59", 32'(value), 32'h5900);
    press(B_MIN);
    step(1);
    check("t5_min_wrap", 32'(value), 32'h0000);
    press(B_SEC);
    press(B_START);
    step(2);
    press(B_START | B_STOP);
    step(1);
    check("t5_stop_beats_start", 32'(running), 32'h0);
    check("t5_stop_value", 32'(value), 32'h0001);
    press(B_START);
    step(9);
    press(B_STOP);
    step(1);
    check("t5_tick_stop_alarm", 32'(alarm), 32'h0);
    check("t5_tick_stop_run", 32'(running), 32'h0);
    step(5);
    check("t5_tick_stop_later", 32'(alarm), 32'h0);

    // Alarm persistence / auto-silence
    do_reset();
    press(B_SEC);
    press(B_START);
    step(11);
    check("t6_alarm_on", 32'(alarm), 32'h1);
`ifdef AUTO_SILENCE_EN
    step(29);
    check("t6_silence_pre", 32'(alarm), 32'h1);
    step(1);
    check("t6_silenced", 32'(alarm), 32'h0);
    check("t6_silenced_value", 32'(value), 32'h0001);
`else
    step(1000);
    check("t6_persist", 32'(alarm), 32'h1);
    check("t6_persist_any", 32'(alarm_any), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
